// File: rtl/alu_share_ctrl_pkg.sv
// Shared types for the two-requester ALU front-end: opcodes, FSM states and
// the operand/result payloads passed to the shared ALU.
package alu_share_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOR = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_SLT = 3'b110,
        OP_SLL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_op_e           op;
    } alu_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] f;
        logic              zf;
        logic              of;
    } alu_rsp_t;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational 32-bit ALU shared by both requesters.
module alu_share_ctrl_alu
    import alu_share_ctrl_pkg::*;
(
    input  alu_req_t req_i,
    output alu_rsp_t rsp_o
);

    logic              is_sub;
    logic [DATA_W-1:0] b_opnd;
    logic [DATA_W:0]   sum;
    logic              carry_in_msb;

    // SUB reuses the adder as a + ~b + 1 so OF falls out of the same carries
    always_comb begin
        is_sub       = (req_i.op == OP_SUB);
        b_opnd       = is_sub ? ~req_i.b : req_i.b;
        sum          = {1'b0, req_i.a} + {1'b0, b_opnd} + (DATA_W+1)'(is_sub);
        carry_in_msb = req_i.a[DATA_W-1] ^ b_opnd[DATA_W-1] ^ sum[DATA_W-1];
    end

    always_comb begin
        rsp_o = '0;
        case (req_i.op)
            OP_AND: rsp_o.f = req_i.a & req_i.b;
            OP_OR:  rsp_o.f = req_i.a | req_i.b;
            OP_XOR: rsp_o.f = req_i.a ^ req_i.b;
            OP_NOR: rsp_o.f = ~(req_i.a | req_i.b);
            OP_ADD, OP_SUB: begin
                rsp_o.f  = sum[DATA_W-1:0];
                rsp_o.of = carry_in_msb ^ sum[DATA_W];
            end
            OP_SLT: rsp_o.f = DATA_W'(req_i.a < req_i.b);
            OP_SLL: rsp_o.f = (req_i.a >= DATA_W) ? '0 : (req_i.b << req_i.a[SHAMT_W-1:0]);
        endcase
        rsp_o.zf = (rsp_o.f == '0);
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin front-end sharing one ALU between two requesters: accept,
// execute, then hold the registered result until the issuer consumes it.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned W    = DATA_W,
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic [OP_W-1:0] req0_op,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    input  logic [OP_W-1:0] req1_op,
    output logic [NREQ-1:0] rsp_valid,
    input  logic [NREQ-1:0] rsp_ready,
    output logic [W-1:0]    rsp_f,
    output logic            rsp_zf,
    output logic            rsp_of,
    output logic            busy
);

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic            id_q, id_d;
    alu_req_t        opnd_q, opnd_d;
    alu_rsp_t        rsp_q, rsp_d;
    alu_rsp_t        alu_rsp;
    logic [NREQ-1:0] grant;

    alu_share_ctrl_alu u_alu (
        .req_i (opnd_q),
        .rsp_o (alu_rsp)
    );

    // A lone requester always wins; on a tie the priority pointer decides
    always_comb begin
        grant = req_valid;
        if (&req_valid) begin
            grant = prio_q ? NREQ'(2'b10) : NREQ'(2'b01);
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        id_d      = id_q;
        opnd_d    = opnd_q;
        rsp_d     = rsp_q;
        req_ready = '0;
        rsp_valid = '0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = rst ? '0 : grant;
                if (|grant) begin
                    id_d    = grant[1];
                    prio_d  = ~grant[1];
                    opnd_d  = grant[1] ? '{a: req1_a, b: req1_b, op: alu_op_e'(req1_op)}
                                       : '{a: req0_a, b: req0_b, op: alu_op_e'(req0_op)};
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_d   = alu_rsp;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Result is suppressed while reset is pending: the op is being discarded
                rsp_valid = rst ? '0 : (NREQ'(1) << id_q);
                if (rsp_ready[id_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            opnd_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            opnd_q  <= opnd_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rsp_f  = rsp_q.f;
    assign rsp_zf = rsp_q.zf;
    assign rsp_of = rsp_q.of;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_f;
    logic        rsp_zf, rsp_of, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_op   (req0_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_op   (req1_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_zf    (rsp_zf),
        .rsp_of    (rsp_of),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU: {f, zf, of}; overflow taken as the signed result leaving the 32-bit range
    function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint      s;
        longint      lim;
        logic [31:0] f;
        logic        o;
        lim = 2147483647;
        o   = 1'b0;
        f   = '0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin
                s = longint'($signed(a)) + longint'($signed(b));
                f = a + b;
                o = (s > lim) || (s < -lim - 1);
            end
            3'd5: begin
                s = longint'($signed(a)) - longint'($signed(b));
                f = a - b;
                o = (s > lim) || (s < -lim - 1);
            end
            3'd6: f = (a < b) ? 32'd1 : 32'd0;
            default: f = b << a;
        endcase
        return {f, f == 32'd0, o};
    endfunction

    function automatic logic [1:0] winner(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Behavioural model: m_age counts cycles since the accepted op (-1 = nothing outstanding)
    int          m_age  = -1;
    logic        m_id   = 1'b0;
    logic        m_prio = 1'b0;
    logic [33:0] m_pend = '0;
    logic [33:0] m_rsp  = '0;

    always @(negedge clk) begin
        logic [1:0] e_ready;
        logic [1:0] e_valid;
        logic       e_busy;
        e_ready = 2'b00;
        e_valid = 2'b00;
        e_busy  = (m_age >= 0);
        if (!rst && m_age < 0) e_ready = winner(req_valid, m_prio);
        if (!rst && m_age >= 2) e_valid = m_id ? 2'b10 : 2'b01;
        chk("m_req_ready", 34'(req_ready), 34'(e_ready));
        chk("m_rsp_valid", 34'(rsp_valid), 34'(e_valid));
        chk("m_busy", 34'(busy), 34'(e_busy));
        chk("m_result", {rsp_f, rsp_zf, rsp_of}, m_rsp);
        if (rst) begin
            m_age  = -1;
            m_prio = 1'b0;
            m_rsp  = '0;
        end else if (m_age < 0) begin
            if (e_ready != 2'b00) begin
                m_id   = e_ready[1];
                m_prio = ~e_ready[1];
                m_pend = e_ready[1] ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
                m_age  = 1;
            end
        end else if (m_age == 1) begin
            m_rsp = m_pend;
            m_age = 2;
        end else if (rsp_ready[m_id]) begin
            m_age = -1;
        end else begin
            m_age++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        req_valid = 2'b00;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    // Issue one op from requester id (called just after a rising edge) and check the literal result
    task automatic directed_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic [31:0] ef, input logic ez, input logic eo);
        int n;
        logic [1:0] mask;
        mask = id ? 2'b10 : 2'b01;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_a = a; req0_b = b; req0_op = op;
        end
        req_valid = mask;
        rsp_ready = 2'b11;
        n = 0;
        @(negedge clk);
        while (req_ready !== mask && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 34'(req_ready), 34'(mask));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        n = 1;
        @(negedge clk);
        while (rsp_valid[id] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 34'(n), 34'(2));
        chk("rsp_valid", 34'(rsp_valid), 34'(mask));
        chk("result", {rsp_f, rsp_zf, rsp_of}, {ef, ez, eo});
        cyc();
    endtask

    task automatic gen(output logic [31:0] a, output logic [31:0] b, output logic [2:0] op);
        logic [31:0] sp [4];
        sp[0] = 32'h0; sp[1] = 32'hFFFF_FFFF; sp[2] = 32'h7FFF_FFFF; sp[3] = 32'h8000_0000;
        op = 3'($urandom_range(0, 7));
        a  = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
        b  = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
        if (op == 3'd7 && $urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 40));
    endtask

    initial begin
        int          acc_cyc [$];
        logic        acc_id [$];
        logic [1:0]  acc;

        // Reset state
        do_reset(3);
        @(negedge clk);
        chk("rst_busy", 34'(busy), 34'(0));
        chk("rst_rsp_valid", 34'(rsp_valid), 34'(0));
        chk("rst_req_ready", 34'(req_ready), 34'(0));
        chk("rst_result", {rsp_f, rsp_zf, rsp_of}, 34'(0));
        cyc();

        directed_op(1'b0, 32'h7FFF_FFFF, 32'h1, 3'd4, 32'h8000_0000, 1'b0, 1'b1);
        directed_op(1'b1, 32'd5, 32'd5, 3'd5, 32'h0, 1'b1, 1'b0);

        // Both requesters always valid: alternating grants every 3 cycles
        do_reset(2);
        req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 3'd6;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = 3'd6;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (|req_ready) begin
                acc_cyc.push_back(c);
                acc_id.push_back(req_ready[1]);
            end
            if (|rsp_valid) chk("slt_f", {rsp_f, rsp_zf, rsp_of}, {32'h0, 1'b1, 1'b0});
            cyc();
        end
        req_valid = 2'b00;
        chk("rr_accepts", 34'(acc_cyc.size() >= 4), 34'(1));
        for (int k = 0; k < 4; k++) begin
            if (k < acc_cyc.size()) begin
                chk("rr_grant", 34'(acc_id[k]), 34'(k % 2));
                if (k > 0) chk("rr_gap", 34'(acc_cyc[k] - acc_cyc[k-1]), 34'(3));
            end
        end

        // Back-pressure with a pending requester 1
        do_reset(2);
        rsp_ready = 2'b00;
        req0_a = 32'd4; req0_b = 32'd1; req0_op = 3'd7;
        req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'd4;
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_accept", 34'(req_ready), 34'(2'b01));
        cyc();
        req_valid = 2'b10;
        cyc();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 34'(rsp_valid), 34'(2'b01));
            chk("bp_f", 34'(rsp_f), 34'(32'h10));
            chk("bp_busy", 34'(busy), 34'(1));
            chk("bp_ready", 34'(req_ready), 34'(0));
            cyc();
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("bp_hold", 34'(rsp_valid), 34'(2'b01));
        cyc();
        @(negedge clk);
        chk("bp_next_accept", 34'(req_ready), 34'(2'b10));
        cyc();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) cyc();

        // Reset while the op is in EXEC
        req0_a = 32'hFFFF; req0_b = 32'hFF; req0_op = 3'd0;
        req_valid = 2'b01;
        @(negedge clk);
        chk("rx_accept", 34'(req_ready), 34'(2'b01));
        cyc();
        req_valid = 2'b00;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rx_busy", 34'(busy), 34'(0));
        chk("rx_result", {rsp_f, rsp_zf, rsp_of}, 34'(0));
        for (int c = 0; c < 5; c++) begin
            chk("rx_no_rsp", 34'(rsp_valid), 34'(0));
            @(negedge clk);
        end
        cyc();
        directed_op(1'b1, 32'h0, 32'h0, 3'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
        directed_op(1'b0, 32'd32, 32'hFFFF_FFFF, 3'd7, 32'h0, 1'b1, 1'b0);

        // Randomized traffic: model checker covers every cycle
        acc = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        if (i == 0) gen(req0_a, req0_b, req0_op);
                        else        gen(req1_a, req1_b, req1_op);
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
            @(negedge clk);
            acc = req_valid & req_ready;
            cyc();
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
